// File: rtl/memory_operand_sequencer_pkg.sv
// Shared types for the memory operand sequencer:
// FSM states, request-source select and request-type constants.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ1,
    S_WAIT1,
    S_REQ2,
    S_WAIT2,
    S_DONE,
    S_STREQ,
    S_STWAIT
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SRC1,
    SEL_SRC2,
    SEL_ST
  } sel_e;

  localparam logic LOAD  = 1'b0;
  localparam logic STORE = 1'b1;

endpackage

// File: rtl/memory_operand_sequencer_if.sv
// Bundle of instruction, operand, store and memory-port signals
// around the memory operand sequencer.
interface memory_operand_sequencer_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              instValidIn;
  logic              isMemSrc1In;
  logic              isMemSrc2In;
  logic [ADDR_W-1:0] memAddrSrc1In;
  logic [ADDR_W-1:0] memAddrSrc2In;
  logic [DATA_W-1:0] operand1ValIn;
  logic [DATA_W-1:0] operand2ValIn;
  logic              stallOut;
  logic [DATA_W-1:0] operand1ValOut;
  logic [DATA_W-1:0] operand2ValOut;
  logic              operandsValidOut;
  logic              operandsReadyIn;
  logic              storeValidIn;
  logic [ADDR_W-1:0] storeAddrIn;
  logic [DATA_W-1:0] storeDataIn;
  logic              storeDoneOut;
  logic              memReqValidOut;
  logic              memReqReadyIn;
  logic              memReqWriteOut;
  logic [ADDR_W-1:0] memReqAddrOut;
  logic [DATA_W-1:0] memReqDataOut;
  logic              memRespValidIn;
  logic [DATA_W-1:0] memRespDataIn;

  modport slave (
    input  instValidIn, isMemSrc1In, isMemSrc2In,
    input  memAddrSrc1In, memAddrSrc2In,
    input  operand1ValIn, operand2ValIn,
    output stallOut, operand1ValOut, operand2ValOut,
    output operandsValidOut,
    input  operandsReadyIn,
    input  storeValidIn, storeAddrIn, storeDataIn,
    output storeDoneOut,
    output memReqValidOut, memReqWriteOut,
    output memReqAddrOut, memReqDataOut,
    input  memReqReadyIn,
    input  memRespValidIn, memRespDataIn
  );

  modport master (
    output instValidIn, isMemSrc1In, isMemSrc2In,
    output memAddrSrc1In, memAddrSrc2In,
    output operand1ValIn, operand2ValIn,
    input  stallOut, operand1ValOut, operand2ValOut,
    input  operandsValidOut,
    output operandsReadyIn,
    output storeValidIn, storeAddrIn, storeDataIn,
    input  storeDoneOut,
    input  memReqValidOut, memReqWriteOut,
    input  memReqAddrOut, memReqDataOut,
    output memReqReadyIn,
    output memRespValidIn, memRespDataIn
  );
endinterface

// File: rtl/memory_operand_sequencer_mem_port_mux.sv
// Selects the fields of the single shared memory request:
// src1 load, src2 load or writeback store; all zero when idle.
module mem_port_mux
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  sel_e              sel_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              valid_o,
  output logic              write_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    valid_o = 1'b0;
    write_o = LOAD;
    addr_o  = '0;
    data_o  = '0;
    unique case (sel_i)
      SEL_SRC1: begin
        valid_o = 1'b1;
        addr_o  = addr1_i;
      end
      SEL_SRC2: begin
        valid_o = 1'b1;
        addr_o  = addr2_i;
      end
      SEL_ST: begin
        valid_o = 1'b1;
        write_o = STORE;
        addr_o  = st_addr_i;
        data_o  = st_data_i;
      end
      SEL_NONE: ;
    endcase
  end

endmodule

// File: rtl/memory_operand_sequencer.sv
// Fetches memory operands for one instruction over a shared port,
// interleaving writeback stores, and hands resolved operands to execute.
module memory_operand_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic clk,
  input logic reset,
  memory_operand_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  logic [ADDR_W-1:0] a2_q, a2_d;
  logic              m2_q, m2_d;
  logic              ld_pend_q, ld_pend_d;
  logic              st_done_q, st_done_d;
  sel_e              sel;

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  mem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel_i     (sel),
    .addr1_i   (a1_q),
    .addr2_i   (a2_q),
    .st_addr_i (bus.storeAddrIn),
    .st_data_i (bus.storeDataIn),
    .valid_o   (req_valid),
    .write_o   (req_write),
    .addr_o    (req_addr),
    .data_o    (req_data)
  );

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    m2_d      = m2_q;
    ld_pend_d = ld_pend_q;
    st_done_d = 1'b0;
    sel       = SEL_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (bus.storeValidIn) begin
          ret_d   = S_IDLE;
          state_d = S_STREQ;
        end else if (bus.instValidIn) begin
          op1_d = bus.operand1ValIn;
          op2_d = bus.operand2ValIn;
          a1_d  = bus.memAddrSrc1In;
          a2_d  = bus.memAddrSrc2In;
          m2_d  = bus.isMemSrc2In;
          if (bus.isMemSrc1In)      state_d = S_REQ1;
          else if (bus.isMemSrc2In) state_d = S_REQ2;
          else                      state_d = S_DONE;
        end
      end
      S_REQ1, S_REQ2: begin
        // a load already on the port must stay until accepted
        if (bus.storeValidIn && !ld_pend_q) begin
          ret_d   = state_q;
          state_d = S_STREQ;
        end else begin
          sel = (state_q == S_REQ1) ? SEL_SRC1 : SEL_SRC2;
          if (bus.memReqReadyIn) begin
            ld_pend_d = 1'b0;
            state_d   = (state_q == S_REQ1) ? S_WAIT1 : S_WAIT2;
          end else begin
            ld_pend_d = 1'b1;
          end
        end
      end
      S_WAIT1: begin
        if (bus.memRespValidIn) begin
          op1_d   = bus.memRespDataIn;
          state_d = m2_q ? S_REQ2 : S_DONE;
        end
      end
      S_WAIT2: begin
        if (bus.memRespValidIn) begin
          op2_d   = bus.memRespDataIn;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.operandsReadyIn) state_d = S_IDLE;
      end
      S_STREQ: begin
        sel = SEL_ST;
        if (bus.memReqReadyIn) state_d = S_STWAIT;
      end
      S_STWAIT: begin
        if (bus.memRespValidIn) begin
          st_done_d = 1'b1;
          state_d   = ret_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      op1_q     <= '0;
      op2_q     <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      m2_q      <= 1'b0;
      ld_pend_q <= 1'b0;
      st_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      m2_q      <= m2_d;
      ld_pend_q <= ld_pend_d;
      st_done_q <= st_done_d;
    end
  end

  assign bus.stallOut         = (state_q != S_IDLE) || bus.storeValidIn;
  assign bus.operandsValidOut = (state_q == S_DONE);
  assign bus.operand1ValOut   = op1_q;
  assign bus.operand2ValOut   = op2_q;
  assign bus.storeDoneOut     = st_done_q;
  assign bus.memReqValidOut   = req_valid;
  assign bus.memReqWriteOut   = req_write;
  assign bus.memReqAddrOut    = req_addr;
  assign bus.memReqDataOut    = req_data;

endmodule
